// File: rtl/sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_ctrl_pkg
//  Description : Shared types and constants for the asynchronous SRAM
//                controller (state encoding, strobe level, counter width).
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_SETUP = 3'd1,
    WR_PULSE = 3'd2,
    WR_HOLD  = 3'd3,
    RD_ACT   = 3'd4,
    RD_TURN  = 3'd5
  } state_t;

  // Chip strobes are active low; this is the deasserted level
  localparam logic c_STROBE_OFF = 1'b1;

  // Wait-state counter width (covers the 1..15 cycle range)
  localparam int c_CNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_ctrl
//  Description : Single-beat host request to asynchronous SRAM strobe
//                sequencer with programmable read wait and write pulse
//                lengths. All chip-side outputs come straight from flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int RD_WAIT_CYC  = 2,   // legal 1..15
  parameter int WR_PULSE_CYC = 1    // legal 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  output logic              mem_cs_n,
  output logic              mem_we_n,
  output logic              mem_oe_n
);

  // Counter preload values: the counter runs count-1 down to 0
  localparam logic [c_CNT_W-1:0] c_RD_LOAD = c_CNT_W'(RD_WAIT_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_WR_LOAD = c_CNT_W'(WR_PULSE_CYC - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  logic                w_accept;
  logic                w_capture;
  logic                w_cs_n;
  logic                w_we_n;
  logic                w_oe_n;
  logic                w_drive;

  logic                r_cs_n;
  logic                r_we_n;
  logic                r_oe_n;
  logic                r_drive;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;

  // Ready only in IDLE and never while reset is being applied
  assign req_ready = (r_state == IDLE) && rst_n;

  // State register and wait counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state sequencing plus strobe levels for the state being entered,
  // so the strobe flops line up exactly with the state register
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          if (req_we) begin
            w_state_nxt = WR_SETUP;
          end else begin
            w_state_nxt = RD_ACT;
            w_cnt_nxt   = c_RD_LOAD;
          end
        end
      end
      WR_SETUP: begin
        w_state_nxt = WR_PULSE;
        w_cnt_nxt   = c_WR_LOAD;
      end
      WR_PULSE: begin
        if (r_cnt == '0) w_state_nxt = WR_HOLD;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      WR_HOLD: w_state_nxt = IDLE;
      RD_ACT: begin
        if (r_cnt == '0) begin
          w_state_nxt = RD_TURN;
          w_capture   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RD_TURN: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_cs_n  = c_STROBE_OFF;
    w_we_n  = c_STROBE_OFF;
    w_oe_n  = c_STROBE_OFF;
    w_drive = 1'b0;
    case (w_state_nxt)
      WR_SETUP, WR_HOLD: begin
        w_cs_n  = ~c_STROBE_OFF;
        w_drive = 1'b1;
      end
      WR_PULSE: begin
        w_cs_n  = ~c_STROBE_OFF;
        w_we_n  = ~c_STROBE_OFF;
        w_drive = 1'b1;
      end
      RD_ACT: begin
        w_cs_n = ~c_STROBE_OFF;
        w_oe_n = ~c_STROBE_OFF;
      end
      default: ;
    endcase
  end

  // Registered chip interface, request latch and read response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cs_n      <= c_STROBE_OFF;
      r_we_n      <= c_STROBE_OFF;
      r_oe_n      <= c_STROBE_OFF;
      r_drive     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_cs_n      <= w_cs_n;
      r_we_n      <= w_we_n;
      r_oe_n      <= w_oe_n;
      r_drive     <= w_drive;
      r_rsp_valid <= w_capture;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_capture) r_rsp_rdata <= mem_data;
    end
  end

  assign mem_cs_n  = r_cs_n;
  assign mem_we_n  = r_we_n;
  assign mem_oe_n  = r_oe_n;
  assign mem_addr  = r_addr;
  assign mem_data  = r_drive ? r_wdata : {DATA_W{1'bz}};
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire
